// File: rtl/mul_requester_if.sv
// Bundle of the signals between mul_requester, its datapath client and the
// multiplier.
//   req_*   : operand request channel (datapath -> requester)
//   resp_*  : result channel (requester -> consumer)
//   mul_*   : cs/ready handshake and operands to/from the multiplier
// Modports:
//   master : the requester itself (drives req_ready, resp_*, mul_cs/a/b)
//   slave  : the environment around it (datapath, consumer, multiplier)
interface mul_requester_if;
  logic        req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_product;
  logic        resp_err;
  logic        resp_ready;
  logic        mul_cs;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_ready;
  logic [15:0] mul_product;

  modport master (
    input  req_valid, req_a, req_b, resp_ready, mul_ready, mul_product,
    output req_ready, resp_valid, resp_product, resp_err, mul_cs, mul_a, mul_b
  );

  modport slave (
    output req_valid, req_a, req_b, resp_ready, mul_ready, mul_product,
    input  req_ready, resp_valid, resp_product, resp_err, mul_cs, mul_a, mul_b
  );
endinterface

// File: rtl/mul_requester.sv
// mul_requester: initiator side of the multiplier cs/ready handshake.
// Takes one operand pair at a time, pulses cs for a single cycle, follows
// the multiplier's ready falling (busy) and rising (done) and captures the
// product on the first edge that samples ready high. Each wait phase is
// bounded by TIMEOUT cycles; on expiry an error response is returned.
//
// Handshakes: a transfer on a valid/ready channel happens on a rising clk
// edge where both valid and ready are 1; valid, once raised, holds its
// payload stable until that edge.
//
// Ports:
//   clk         : system clock, all logic on posedge
//   rst_n       : asynchronous active-low reset
//   bus         : mul_requester_if.master (request, response, multiplier)
//   dbg_state_o : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT_BUSY,
//                 3 WAIT_DONE, 4 RESP)
module mul_requester #(
  parameter int TIMEOUT = 16,  // >= 4
  parameter int CNT_W   = 5    // 2**CNT_W > TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  mul_requester_if.master bus,
  output logic [2:0]      dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [15:0]      resp_product_q, resp_product_d;
  logic             resp_err_q, resp_err_d;
  logic             mul_cs_q, mul_cs_d;
  logic [15:0]      mul_a_q, mul_a_d;
  logic [15:0]      mul_b_q, mul_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      req_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_product_q <= '0;
      resp_err_q     <= 1'b0;
      mul_cs_q       <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_product_q <= resp_product_d;
      resp_err_q     <= resp_err_d;
      mul_cs_q       <= mul_cs_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      cnt_q          <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    req_ready_d    = 1'b0;        // only IDLE may offer ready
    resp_valid_d   = resp_valid_q;
    resp_product_d = resp_product_q;
    resp_err_d     = resp_err_q;
    mul_cs_d       = 1'b0;        // cs defaults low: it can only be a 1-cycle pulse
    mul_a_d        = mul_a_q;     // operands held until the next accept
    mul_b_d        = mul_b_q;
    cnt_d          = cnt_q;
    cnt_inc        = cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          mul_a_d  = bus.req_a;
          mul_b_d  = bus.req_b;
          mul_cs_d = 1'b1;
          state_d  = ISSUE;
        end else begin
          // Ready is registered, so it follows the multiplier's idle flag
          // one cycle late; after RESP this also yields the one-cycle gap.
          req_ready_d = bus.mul_ready;
        end
      end

      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (!bus.mul_ready) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_inc == TIMEOUT_C) begin
          resp_err_d     = 1'b1;
          resp_product_d = '0;
          resp_valid_d   = 1'b1;
          cnt_d          = '0;
          state_d        = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      WAIT_DONE: begin
        if (bus.mul_ready) begin
          // Product is only driven during the first ready-high cycle, so
          // it is captured on this very edge and never later.
          resp_product_d = bus.mul_product;
          resp_err_d     = 1'b0;
          resp_valid_d   = 1'b1;
          state_d        = RESP;
        end else if (cnt_inc == TIMEOUT_C) begin
          resp_err_d     = 1'b1;
          resp_product_d = '0;
          resp_valid_d   = 1'b1;
          cnt_d          = '0;
          state_d        = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_product = resp_product_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.mul_cs       = mul_cs_q;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
  assign dbg_state_o      = state_q;

endmodule

// File: doc/mul_requester.md
Name: mul_requester

Overview:
- Initiator side of the multiplier's cs/ready handshake.
- Accepts operand pairs from the datapath on a valid/ready interface and drives cs and the operands to the multiplier.
- Tracks the multiplier's ready drop and rise, then captures the product in the single cycle it is valid.
- Returns the result on a valid/ready response interface. Each wait phase has a timeout that reports an error instead of hanging.

Parameters:
- TIMEOUT, 16: maximum cycles spent in WAIT_BUSY or WAIT_DONE before aborting; must be ≥4.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  operand pair available
- req_a  in  16  operand A
- req_b  in  16  operand B
- req_ready  out  1  requester can accept a pair
- resp_valid  out  1  result/error held for consumer
- resp_product  out  16  captured product
- resp_err  out  1  transaction timed out; resp_product is 0
- resp_ready  in  1  consumer accepts response
- mul_cs  out  1  chip select to multiplier
- mul_a  out  16  operand A to multiplier (multiplier uses [7:0])
- mul_b  out  16  operand B to multiplier (multiplier uses [7:0])
- mul_ready  in  1  multiplier ready/idle flag
- mul_product  in  16  multiplier product; valid only the cycle after ready rises, Z otherwise

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=IDLE, req_ready=0, resp_valid=0, resp_product=0, resp_err=0
  - mul_cs=0, mul_a=0, mul_b=0, timeout counter=0
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - req_ready=1 only when mul_ready=1.
  - On req_valid & req_ready: latch req_a/req_b into mul_a/mul_b, set mul_cs=1, clear req_ready, go to ISSUE.
- ISSUE, exactly one cycle:
  - mul_cs=0 at the next edge; cs is never high for more than one cycle, so the multiplier cannot retrigger.
  - Clear counter, go to WAIT_BUSY.
- WAIT_BUSY:
  - Counter increments each cycle.
  - mul_ready sampled 0 → clear counter, go to WAIT_DONE.
  - Counter reaches TIMEOUT → error response.
- WAIT_DONE:
  - mul_ready sampled 1 → resp_product<=mul_product on that same edge, resp_err=0, resp_valid=1, go to RESP.
  - Counter reaches TIMEOUT → error response.
- Error response: resp_err=1, resp_product=0, resp_valid=1, go to RESP.
- Capture must occur on the first edge that samples ready=1. The product goes Z one cycle later; a late capture is a bug.
- mul_a/mul_b are held stable from the ISSUE edge until RESP entry.
- RESP:
  - resp_valid, resp_product and resp_err are held until resp_valid & resp_ready.
  - On acceptance: resp_valid=0, go to IDLE; req_ready may go high on the following cycle, no earlier.
- Throughput: at most one transaction outstanding; no pipelining.
- Nominal latency, req accept edge to resp_valid=1: 4 cycles against the standard multiplier.
- Simultaneous events:
  - req_valid while in RESP is ignored; req_ready stays 0.
  - resp_ready while resp_valid=0 has no effect.
- Reset mid-transaction:
  - Aborts immediately; mul_cs drops asynchronously.
  - No response is produced.
  - After release, IDLE waits for mul_ready=1 before accepting.
- A mul_product value of X/Z outside the capture edge must never propagate to resp_product.

Test Plan:
1. Basic: req a=0x0007, b=0x0009 → mul_cs high exactly 1 cycle; resp_valid after 4 cycles; resp_product=0x003F, resp_err=0.
2. Byte truncation: a=0x12FF, b=0x3402 → resp_product=0x01FE; mul_a/mul_b held at 0x12FF/0x3402 from issue to capture.
3. Backpressure: resp_ready=0 for 10 cycles → resp_product=0x003F stable with resp_valid=1; req_ready=0; second req_valid ignored until accept.
4. Timeout: multiplier model never drops ready → resp_err=1, resp_product=0 after TIMEOUT cycles in WAIT_BUSY; repeat with ready stuck 0 to time out in WAIT_DONE.
5. Reset mid-op: assert rst_n=0 in WAIT_DONE → all outputs 0 immediately; after release, a new req 0x0003×0x0005 gives 0x000F.
6. Back-to-back: 3 requests with resp_ready=1 → products 0x0001, 0x0100 (0x10×0x10), 0xFE01 (0xFF×0xFF) in order; never two cs pulses within one transaction.
